fir_input_feeder: RTL and testbench
===================================

# fir_input_feeder

Upstream stage of the FIR filter. Buffers a free-running sample stream in a small FIFO and paces it into the FIR one sample at a time. For each sample it raises the FIR's `input_valid` strobe, then waits for the FIR's `output_valid` to rise and fall before issuing the next sample. A watchdog flags a FIR that never answers.

## Interface

Parameters:
- `WIDTH`, 16: sample width; matches the FIR `WIDTH`.
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `PULSE`, 2: cycles `input_valid` is held high per sample; ≥ 1.
- `TIMEOUT`, 255: maximum cycles spent waiting on `output_valid` per sample; ≥ 1.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `src_data`, in, `WIDTH`: incoming sample.
- `src_valid`, in, 1: `src_data` valid.
- `src_ready`, out, 1: FIFO can accept; a push occurs on `src_valid && src_ready`.
- `FIR_input`, out, `WIDTH`: registered sample to the FIR; held between pops.
- `input_valid`, out, 1: registered strobe to the FIR.
- `output_valid`, in, 1: FIR result-valid, used as the completion handshake.
- `level`, out, `$clog2(DEPTH)+1`: current FIFO occupancy, 0..`DEPTH`.
- `busy`, out, 1: high in every FSM state except IDLE.
- `timeout_err`, out, 1: sticky watchdog flag; cleared only by `reset`.

## Operation

**FIFO**
- Circular buffer with read and write pointers that wrap modulo `DEPTH`, plus an occupancy counter.
- `src_ready = (level != DEPTH) && !reset`. There is no pass-through when full.
- Occupancy update per cycle: push only, +1; pop only, −1; push and pop together, unchanged.
- A pop is generated only by the FSM, in IDLE.

**FSM**: states IDLE, ISSUE, WAIT_HI, WAIT_LO.
- **IDLE**:
  - If `level != 0`, pop the head into `FIR_input`, set `input_valid = 1`, load the pulse counter with `PULSE-1`, and go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**:
  - Hold `input_valid = 1` until the pulse counter reaches 0.
  - Then clear `input_valid`, clear the watchdog, and go to WAIT_HI.
- **WAIT_HI**:
  - On `output_valid == 1`, go to WAIT_LO.
  - Otherwise increment the watchdog.
- **WAIT_LO**:
  - On `output_valid == 0`, go to IDLE.
  - Otherwise increment the watchdog.
- **Watchdog**:
  - The counter is shared by WAIT_HI and WAIT_LO and is not reset between them.
  - When it reaches `TIMEOUT` in either state, set `timeout_err` and go to IDLE.
  - The sample that timed out is dropped; it is not retried.
- **`FIR_input` stability**: changes only on a pop and is stable throughout ISSUE, WAIT_HI and WAIT_LO, as the FIR samples it while computing.

**Reset mid-operation**
- An asynchronous `reset` forces IDLE immediately.
- It empties the FIFO: pointers and `level` go to 0.
- Every output goes to 0: `FIR_input`, `input_valid`, `busy`, `timeout_err`, and `src_ready` while `reset` is high.
- An in-flight FIR computation is abandoned. `output_valid` seen afterwards in IDLE is ignored.

## Timing

- **Reset values**: `src_ready` 0 during reset, then 1 from the first cycle after deassertion. All other outputs are 0.
- **Push into an empty FIFO while in IDLE**:
  - At edge k the push is written and `level` = 1.
  - At edge k+1 the pop occurs: `FIR_input` updates, `input_valid` = 1, `busy` = 1, `level` = 0.
  - This gives 1 cycle of latency from push to strobe.
- **Strobe width**: `input_valid` is high for exactly `PULSE` cycles per sample and is never back-to-back across samples. At least 2 cycles separate pulses (WAIT_HI plus WAIT_LO).
- **`output_valid` already high on entry to WAIT_HI**: taken as the response; WAIT_LO is entered next cycle.
- **Minimum per-sample period**: `PULSE` + 3 cycles, covering one cycle each for IDLE, WAIT_HI and WAIT_LO.
- **Simultaneous push and pop at `level == DEPTH`**: the push is refused because `src_ready` is 0 that cycle, so `level` becomes `DEPTH`−1.
- **Pointer wrap**: pointer `DEPTH`−1 wraps to 0 with no lost or duplicated entry.

## Test plan

- **Reset values**: assert `reset` asynchronously between edges. All outputs go to 0 immediately; after release, `src_ready` = 1 and `level` = 0.
- **Single sample**: push `16'h1234` with the FIR model answering 70 cycles later with a 1-cycle `output_valid`.
  - Next cycle: `FIR_input` = `16'h1234` and `input_valid` is high for 2 cycles.
  - `busy` stays high until the cycle after `output_valid` falls.
- **Fill and order**: push 10 samples, 0..9, back to back with `DEPTH` = 8 and a stalled FIR.
  - `src_ready` drops when `level` = 8.
  - Once the FIR runs, it sees samples in order 0..N with no duplicates across pointer wrap.
- **Full boundary**: at `level` = 8, hold `src_valid` through a pop cycle. `level` goes 8→7, the refused sample is not written, and it is pushed the next cycle (7→8).
- **Timeout**: the FIR model never asserts `output_valid` with `TIMEOUT` = 10.
  - `timeout_err` rises exactly 10 cycles after entering WAIT_HI and stays high.
  - The next queued sample is issued.
- **Reset mid-WAIT_LO**: with `output_valid` held high and 3 samples queued, pulse `reset`. `level` = 0, the FSM is in IDLE, and no `input_valid` is issued afterwards.

Source files
------------

// File: rtl/fir_input_feeder_if.sv
// Sample-stream and FIR handshake bundle for fir_input_feeder.
// The slave modport is the feeder's view; master is the environment (source plus FIR).
interface fir_input_feeder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] src_data;
  logic             src_valid;
  logic             src_ready;
  logic [WIDTH-1:0] FIR_input;
  logic             input_valid;
  logic             output_valid;

  modport slave (
    input  src_data,
    input  src_valid,
    input  output_valid,
    output src_ready,
    output FIR_input,
    output input_valid
  );

  modport master (
    output src_data,
    output src_valid,
    output output_valid,
    input  src_ready,
    input  FIR_input,
    input  input_valid
  );
endinterface

// File: rtl/fir_input_feeder.sv
// FIFO-buffered sample feeder that paces one sample at a time into the FIR,
// waiting for the FIR's output_valid rise/fall with a sticky watchdog flag.
module fir_input_feeder #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int PULSE   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  fir_input_feeder_if.slave        bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (PULSE > 1) ? $clog2(PULSE) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [PW-1:0]     pulse_cnt;
  logic [TW-1:0]     wd_cnt;
  logic              push;
  logic              pop;
  logic              pulse_dec;
  logic              wd_clr;
  logic              wd_inc;
  logic              wd_hit;

  // FIFO handshake: no pass-through when full, and nothing accepted during reset
  always_comb begin
    bus.src_ready = (level != LW'(DEPTH)) && !reset;
    push          = bus.src_valid && bus.src_ready;
    pop           = (state == IDLE) && (level != LW'(0));
  end

  // FSM next-state and control strobes
  always_comb begin
    state_next = state;
    pulse_dec  = 1'b0;
    wd_clr     = 1'b0;
    wd_inc     = 1'b0;
    wd_hit     = 1'b0;
    case (state)
      IDLE: begin
        if (pop) begin
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: begin
        if (pulse_cnt == PW'(0)) begin
          state_next = WAIT_HI;
          wd_clr     = 1'b1;
        end else begin
          pulse_dec  = 1'b1;
        end
      end
      WAIT_HI: begin
        if (bus.output_valid) begin
          state_next = WAIT_LO;
        end else if (wd_cnt == TW'(TIMEOUT - 1)) begin
          state_next = IDLE;
          wd_hit     = 1'b1;
        end else begin
          wd_inc     = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!bus.output_valid) begin
          state_next = IDLE;
        end else if (wd_cnt == TW'(TIMEOUT - 1)) begin
          state_next = IDLE;
          wd_hit     = 1'b1;
        end else begin
          wd_inc     = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state register and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      bus.input_valid <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      state           <= state_next;
      busy            <= (state_next != IDLE);
      // Strobe is high exactly while the FSM sits in ISSUE
      bus.input_valid <= (state_next == ISSUE);
      if (wd_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // Pulse-width counter and shared watchdog counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_cnt <= PW'(0);
      wd_cnt    <= TW'(0);
    end else begin
      if (pop) begin
        pulse_cnt <= PW'(PULSE - 1);
      end else if (pulse_dec) begin
        pulse_cnt <= pulse_cnt - PW'(1);
      end
      if (wd_clr) begin
        wd_cnt <= TW'(0);
      end else if (wd_inc) begin
        wd_cnt <= wd_cnt + TW'(1);
      end
    end
  end

  // FIFO pointers, occupancy and the held FIR sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= AW'(0);
      rd_ptr        <= AW'(0);
      level         <= LW'(0);
      bus.FIR_input <= WIDTH'(0);
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + AW'(1);
        bus.FIR_input <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // FIFO storage; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.src_data;
    end
  end

endmodule

// File: tb/tb_fir_input_feeder.sv
// Directed testbench for fir_input_feeder: reset, single sample, fill/order,
// full boundary, mid-wait reset on one instance and watchdog timeout on another.
module tb_fir_input_feeder;

  logic       clk;
  logic       reset;
  logic [3:0] level_a;
  logic       busy_a;
  logic       to_a;
  logic [3:0] level_b;
  logic       busy_b;
  logic       to_b;
  int         errors;
  int         checks;

  fir_input_feeder_if #(.WIDTH(16)) ifa ();
  fir_input_feeder_if #(.WIDTH(16)) ifb ();

  fir_input_feeder #(.WIDTH(16), .DEPTH(8), .PULSE(2), .TIMEOUT(255)) dut_a (
    .clk         (clk),
    .reset       (reset),
    .bus         (ifa),
    .level       (level_a),
    .busy        (busy_a),
    .timeout_err (to_a)
  );

  fir_input_feeder #(.WIDTH(16), .DEPTH(8), .PULSE(2), .TIMEOUT(10)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .bus         (ifb),
    .level       (level_b),
    .busy        (busy_b),
    .timeout_err (to_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for the next strobe, checks the sample, then answers with a 1-cycle output_valid
  task automatic serve(input logic [15:0] exp, input bit chk_width);
    int n;
    n = 0;
    while (!ifa.input_valid && n < 50) begin
      step();
      n++;
    end
    chk($sformatf("strobe_seen_%0d", exp), ifa.input_valid, 1'b1);
    chk($sformatf("order_%0d", exp), ifa.FIR_input, exp);
    n = 0;
    while (ifa.input_valid && n < 10) begin
      step();
      n++;
    end
    if (chk_width) begin
      chk($sformatf("pulse_width_%0d", exp), n, 32'd2);
    end else begin
      chk($sformatf("strobe_end_%0d", exp), ifa.input_valid, 1'b0);
    end
    ifa.output_valid = 1'b1;
    step();
    ifa.output_valid = 1'b0;
    step();
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: observed=expired expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    ifa.src_data = 16'h0000; ifa.src_valid = 1'b0; ifa.output_valid = 1'b0;
    ifb.src_data = 16'h0000; ifb.src_valid = 1'b0; ifb.output_valid = 1'b0;

    // Reset values
    step(); step();
    chk("rst_src_ready", ifa.src_ready, 1'b0);
    chk("rst_fir_input", ifa.FIR_input, 16'h0000);
    chk("rst_input_valid", ifa.input_valid, 1'b0);
    chk("rst_level", level_a, 4'd0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_timeout", to_a, 1'b0);
    reset = 1'b0;
    #1;
    chk("rel_src_ready", ifa.src_ready, 1'b1);
    chk("rel_level", level_a, 4'd0);

    // Single sample, FIR answers about 70 cycles later
    ifa.src_data = 16'h1234;
    ifa.src_valid = 1'b1;
    step();
    chk("single_level_push", level_a, 4'd1);
    chk("single_iv_before", ifa.input_valid, 1'b0);
    ifa.src_valid = 1'b0;
    step();
    chk("single_fir_input", ifa.FIR_input, 16'h1234);
    chk("single_iv_1", ifa.input_valid, 1'b1);
    chk("single_busy", busy_a, 1'b1);
    chk("single_level_pop", level_a, 4'd0);
    step();
    chk("single_iv_2", ifa.input_valid, 1'b1);
    step();
    chk("single_iv_off", ifa.input_valid, 1'b0);
    chk("single_busy_wait", busy_a, 1'b1);
    repeat (66) step();
    chk("single_busy_long", busy_a, 1'b1);
    chk("single_fir_hold", ifa.FIR_input, 16'h1234);
    ifa.output_valid = 1'b1;
    step();
    ifa.output_valid = 1'b0;
    chk("single_busy_wait_lo", busy_a, 1'b1);
    step();
    chk("single_busy_done", busy_a, 1'b0);
    chk("single_no_timeout", to_a, 1'b0);

    // Fill with a stalled FIR: sample 0 is in flight, 1..8 fill the FIFO
    for (int d = 0; d < 9; d++) begin
      ifa.src_data = 16'(d);
      ifa.src_valid = 1'b1;
      step();
    end
    chk("fill_level_full", level_a, 4'd8);
    chk("fill_src_ready_low", ifa.src_ready, 1'b0);
    chk("fill_first_out", ifa.FIR_input, 16'h0000);

    // Full boundary: sample 9 held on src_valid through the pop cycle
    ifa.src_data = 16'h0009;
    ifa.output_valid = 1'b1;
    step();
    ifa.output_valid = 1'b0;
    step();
    chk("full_idle_level", level_a, 4'd8);
    chk("full_idle_ready", ifa.src_ready, 1'b0);
    step();
    chk("full_pop_level", level_a, 4'd7);
    chk("full_pop_ready", ifa.src_ready, 1'b1);
    chk("full_pop_sample", ifa.FIR_input, 16'h0001);
    step();
    chk("full_repush_level", level_a, 4'd8);
    chk("full_repush_ready", ifa.src_ready, 1'b0);
    ifa.src_valid = 1'b0;

    // Drain: order 1..9 across pointer wrap
    serve(16'h0001, 1'b0);
    for (int d = 2; d < 10; d++) begin
      serve(16'(d), 1'b1);
    end
    step();
    chk("drain_level", level_a, 4'd0);
    chk("drain_busy", busy_a, 1'b0);

    // Reset while in WAIT_LO with 3 samples queued
    for (int d = 0; d < 4; d++) begin
      ifa.src_data = 16'hA0 + 16'(d);
      ifa.src_valid = 1'b1;
      step();
    end
    ifa.src_valid = 1'b0;
    chk("mid_wait_hi_iv", ifa.input_valid, 1'b0);
    chk("mid_level_pre", level_a, 4'd3);
    ifa.output_valid = 1'b1;
    step();
    chk("mid_busy_wait_lo", busy_a, 1'b1);
    chk("mid_level_wait_lo", level_a, 4'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("async_level", level_a, 4'd0);
    chk("async_busy", busy_a, 1'b0);
    chk("async_fir_input", ifa.FIR_input, 16'h0000);
    chk("async_iv", ifa.input_valid, 1'b0);
    chk("async_src_ready", ifa.src_ready, 1'b0);
    step();
    reset = 1'b0;
    #1;
    chk("mid_rel_ready", ifa.src_ready, 1'b1);
    chk("mid_rel_level", level_a, 4'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mid_no_strobe", ifa.input_valid, 1'b0);
      chk("mid_idle_busy", busy_a, 1'b0);
    end
    ifa.output_valid = 1'b0;

    // Watchdog on the TIMEOUT=10 instance with a silent FIR
    ifb.src_data = 16'hAAAA;
    ifb.src_valid = 1'b1;
    step();
    ifb.src_data = 16'hBBBB;
    step();
    ifb.src_valid = 1'b0;
    chk("to_first_sample", ifb.FIR_input, 16'hAAAA);
    chk("to_first_iv", ifb.input_valid, 1'b1);
    step();
    step();
    chk("to_wait_hi_iv", ifb.input_valid, 1'b0);
    chk("to_wait_hi_busy", busy_b, 1'b1);
    repeat (9) step();
    chk("to_not_yet", to_b, 1'b0);
    chk("to_still_busy", busy_b, 1'b1);
    step();
    chk("to_raised", to_b, 1'b1);
    chk("to_idle", busy_b, 1'b0);
    step();
    chk("to_next_sample", ifb.FIR_input, 16'hBBBB);
    chk("to_next_iv", ifb.input_valid, 1'b1);
    chk("to_sticky", to_b, 1'b1);
    repeat (20) step();
    chk("to_sticky_late", to_b, 1'b1);
    chk("to_second_dropped", busy_b, 1'b0);

    // Only reset clears the sticky flag
    reset = 1'b1;
    #1;
    chk("to_reset_clear", to_b, 1'b0);
    step();
    reset = 1'b0;
    step();
    chk("to_after_reset", to_b, 1'b0);
    chk("to_after_reset_level", level_b, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
